// File: rtl/cpu_pkg.sv
// Shared pipeline definitions for the IF/ID boundary of the 5-stage MIPS core.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  // One fetched instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_decode_queue.sv
// Instruction queue between fetch and decode. Show-ahead output, explicit
// occupancy count, and a flush that discards every buffered entry when decode
// resolves a taken branch.
module fetch_decode_queue
  import cpu_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned XLEN  = cpu_pkg::XLEN,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enq_valid,
  input  logic [XLEN-1:0] enq_pc,
  input  logic [XLEN-1:0] enq_instr,
  output logic            enq_ready,
  output logic            deq_valid,
  output logic [XLEN-1:0] deq_pc,
  output logic [XLEN-1:0] deq_pc_plus4,
  output logic [XLEN-1:0] deq_instr,
  input  logic            deq_ready,
  input  logic            flush,
  output logic [AW:0]     count
);

  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0] EMPTY_CNT = '0;

  // Each slot holds {pc, instr}; pc occupies the upper half.
  logic [2*XLEN-1:0] mem [DEPTH];

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              enq_fire;
  logic              deq_fire;
  logic              not_empty;
  logic [2*XLEN-1:0] head;

  // Handshake decode; full and empty come from the registered count only.
  always_comb begin
    not_empty = (count != EMPTY_CNT);
    enq_ready = (count != FULL_CNT);
    deq_valid = not_empty && !flush;
    enq_fire  = enq_valid && enq_ready && !flush;
    deq_fire  = deq_valid && deq_ready;
  end

  // Pointer and occupancy state; flush returns everything to the origin.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_fire) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (deq_fire) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (enq_fire && !deq_fire) begin
        count <= count + (AW+1)'(1);
      end else if (deq_fire && !enq_fire) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

  // Storage write; contents are left as-is on reset and flush.
  always_ff @(posedge clk) begin
    if (rst_n && enq_fire) begin
      mem[wr_ptr] <= {enq_pc, enq_instr};
    end
  end

  // Head entry presentation; storage is masked while empty so unwritten
  // slots never reach decode.
  always_comb begin
    head         = mem[rd_ptr];
    deq_pc       = '0;
    deq_instr    = XLEN'(NOP_INSTR);
    if (not_empty) begin
      deq_pc    = head[2*XLEN-1:XLEN];
      deq_instr = head[XLEN-1:0];
    end
    deq_pc_plus4 = deq_pc + XLEN'(PC_STEP);
  end

endmodule
